// File: rtl/ldpc_rom_seq_pkg.sv
// ldpc_rom_seq_pkg: shared definitions for the two-rate LDPC table sequencer.
// Build option: LDPC_ROM_OREG_EN adds a ROM output register (read latency 2).
package ldpc_rom_seq_pkg;

    // Encodings seen on the rate port
    localparam logic RATE_1_2 = 1'b0;
    localparam logic RATE_3_4 = 1'b1;

    // Default CMMB table placement inside the ROM
    localparam int CMMB_BASE_1_2 = 32'sd0;
    localparam int CMMB_LEN_1_2  = 32'sd4608;
    localparam int CMMB_BASE_3_4 = 32'sd4608;
    localparam int CMMB_LEN_3_4  = 32'sd3456;

    // ROM read latency and the prefetch depth needed to hide it
`ifdef LDPC_ROM_OREG_EN
    localparam int ROM_RL = 32'sd2;
`else
    localparam int ROM_RL = 32'sd1;
`endif
    localparam int FIFO_DEPTH = ROM_RL + 32'sd1;

    // Sequencer FSM state codes
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Table content generator; stands in for the parity-check table image
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        rom_word = ((addr * 32'd37) + 32'd5) ^ (addr >> 3);
    endfunction

endpackage

// File: rtl/ldpc_rom_tbl.sv
// ldpc_rom_tbl: synchronous parity-check table ROM.
// The table image is selected here (generated by rom_word in the package).
// Build option: LDPC_ROM_OREG_EN adds an output register stage.
module ldpc_rom_tbl
    import ldpc_rom_seq_pkg::*;
#(
    parameter int DW = 14,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] word_s;
    logic [DW-1:0] rd_q;

    assign word_s = DW'(rom_word(32'(addr)));

    // Synchronous read port of the table
    always_ff @(posedge clk) begin
        rd_q <= word_s;
    end

`ifdef LDPC_ROM_OREG_EN
    logic [DW-1:0] oreg_q;

    // Output register stage for timing closure
    always_ff @(posedge clk) begin
        oreg_q <= rd_q;
    end

    assign dout = oreg_q;
`else
    assign dout = rd_q;
`endif

endmodule

// File: rtl/ldpc_rom_seq.sv
// ldpc_rom_seq: streams the selected rate's parity-check table once per
// decoder iteration over a valid/ready port, with a prefetch FIFO that hides
// ROM read latency. Build option: LDPC_ROM_OREG_EN (ROM latency 2, depth 3).
module ldpc_rom_seq
    import ldpc_rom_seq_pkg::*;
#(
    parameter int DW    = 14,
    parameter int AW    = 13,
    parameter int BASE0 = CMMB_BASE_1_2,
    parameter int LEN0  = CMMB_LEN_1_2,
    parameter int BASE1 = CMMB_BASE_3_4,
    parameter int LEN1  = CMMB_LEN_3_4,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rate,
    input  logic [IW-1:0] iter_num,
    input  logic          abort,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          dout_last,
    output logic [IW-1:0] pass_idx,
    output logic          done
);

    seq_state_e    state_q;
    logic          rate_q, busy_q, done_q;
    logic [IW-1:0] iter_q, pcnt_q;
    logic [AW-1:0] raddr_q, ecnt_q;

    // In-flight read tracking, aligned with the ROM pipeline
    logic [ROM_RL-1:0] pv_q, pl_q;
    logic [IW-1:0]     pp_q [ROM_RL];

    // Prefetch FIFO kept as a shift register: slot 0 is the output head
    logic [FIFO_DEPTH-1:0] fv_q, fv_d, fl_q, fl_d;
    logic [DW-1:0]         fd_q [FIFO_DEPTH];
    logic [DW-1:0]         fd_d [FIFO_DEPTH];
    logic [IW-1:0]         fp_q [FIFO_DEPTH];
    logic [IW-1:0]         fp_d [FIFO_DEPTH];

    logic          start_acc_s, sel_rate_s, pass_end_s, run_end_s;
    logic          pop_s, push_s, room_s, issue_s, final_xfer_s, placed_s;
    logic [IW-1:0] sel_iter_s, cur_pcnt_s;
    logic [AW-1:0] base_s, len_m1_s, cur_addr_s, cur_ecnt_s;
    logic [DW-1:0] rom_dout_s;
    int            fifo_cnt_s, infl_cnt_s;

    ldpc_rom_tbl #(.DW(DW), .AW(AW)) u_tbl (
        .clk  (clk),
        .addr (cur_addr_s),
        .dout (rom_dout_s)
    );

    // Select the entry to read this cycle; the start cycle reads entry 0 directly
    always_comb begin
        start_acc_s = (state_q == ST_IDLE) && !done_q && start && !abort;
        sel_rate_s  = start_acc_s ? rate : rate_q;
        sel_iter_s  = start_acc_s ? iter_num : iter_q;
        case (sel_rate_s)
            RATE_1_2: begin
                base_s   = AW'(BASE0);
                len_m1_s = AW'(LEN0 - 32'sd1);
            end
            RATE_3_4: begin
                base_s   = AW'(BASE1);
                len_m1_s = AW'(LEN1 - 32'sd1);
            end
            default: begin
                base_s   = AW'(BASE0);
                len_m1_s = AW'(LEN0 - 32'sd1);
            end
        endcase
        cur_addr_s = start_acc_s ? base_s : raddr_q;
        cur_ecnt_s = start_acc_s ? '0 : ecnt_q;
        cur_pcnt_s = start_acc_s ? '0 : pcnt_q;
        pass_end_s = (cur_ecnt_s == len_m1_s);
        run_end_s  = pass_end_s && (cur_pcnt_s == sel_iter_s);
    end

    // Occupancy and read-issue decision; the head leaving this cycle frees a slot
    always_comb begin
        fifo_cnt_s = 32'sd0;
        infl_cnt_s = 32'sd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_cnt_s = fifo_cnt_s + int'(fv_q[i]);
        end
        for (int i = 0; i < ROM_RL; i++) begin
            infl_cnt_s = infl_cnt_s + int'(pv_q[i]);
        end
        pop_s        = fv_q[0] && dout_rdy;
        push_s       = pv_q[ROM_RL-1];
        room_s       = (fifo_cnt_s + infl_cnt_s + 32'sd1 - int'(pop_s)) <= FIFO_DEPTH;
        issue_s      = !abort && (start_acc_s || ((state_q == ST_RUN) && room_s));
        final_xfer_s = (state_q == ST_DRAIN) && pop_s &&
                       (fifo_cnt_s == 32'sd1) && (infl_cnt_s == 32'sd0);
    end

    // Control FSM, table counters, busy and done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rate_q  <= 1'b0;
            iter_q  <= '0;
            raddr_q <= '0;
            ecnt_q  <= '0;
            pcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= final_xfer_s;
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        rate_q  <= rate;
                        iter_q  <= iter_num;
                        busy_q  <= 1'b1;
                        state_q <= run_end_s ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue_s && run_end_s) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (final_xfer_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (issue_s) begin
                if (pass_end_s) begin
                    raddr_q <= base_s;
                    ecnt_q  <= '0;
                    pcnt_q  <= cur_pcnt_s + IW'(1'b1);
                end else begin
                    raddr_q <= cur_addr_s + AW'(1'b1);
                    ecnt_q  <= cur_ecnt_s + AW'(1'b1);
                    pcnt_q  <= cur_pcnt_s;
                end
            end
        end
    end

    // Carry valid/last/pass alongside each outstanding ROM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            pl_q <= '0;
            for (int i = 0; i < ROM_RL; i++) begin
                pp_q[i] <= '0;
            end
        end else if (abort) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= issue_s;
            pl_q[0] <= pass_end_s;
            pp_q[0] <= cur_pcnt_s;
            for (int i = 1; i < ROM_RL; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
                pp_q[i] <= pp_q[i-1];
            end
        end
    end

    // FIFO next state: shift out the head on transfer, append returning read
    always_comb begin
        fv_d     = fv_q;
        fl_d     = fl_q;
        fd_d     = fd_q;
        fp_d     = fp_q;
        placed_s = 1'b0;
        if (pop_s) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fv_d[i] = fv_q[i+1];
                fl_d[i] = fl_q[i+1];
                fd_d[i] = fd_q[i+1];
                fp_d[i] = fp_q[i+1];
            end
            fv_d[FIFO_DEPTH-1] = 1'b0;
        end else begin
            fv_d = fv_q;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push_s && !placed_s && !fv_d[i]) begin
                fv_d[i]  = 1'b1;
                fl_d[i]  = pl_q[ROM_RL-1];
                fd_d[i]  = rom_dout_s;
                fp_d[i]  = pp_q[ROM_RL-1];
                placed_s = 1'b1;
            end else begin
                placed_s = placed_s;
            end
        end
    end

    // FIFO storage; abort drops every queued entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fv_q <= '0;
            fl_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fd_q[i] <= '0;
                fp_q[i] <= '0;
            end
        end else if (abort) begin
            fv_q <= '0;
        end else begin
            fv_q <= fv_d;
            fl_q <= fl_d;
            fd_q <= fd_d;
            fp_q <= fp_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dout      = fd_q[0];
    assign dout_vld  = fv_q[0];
    assign dout_last = fl_q[0];
    assign pass_idx  = fp_q[0];

endmodule

// File: tb/tb_ldpc_rom_seq.sv
// tb_ldpc_rom_seq: randomized self-checking bench for ldpc_rom_seq.
// Expected streams are built from the table rules (base, length, passes).
module tb_ldpc_rom_seq;

    localparam int DW    = 14;
    localparam int AW    = 13;
    localparam int IW    = 4;
    localparam int BASE0 = 0;
    localparam int LEN0  = 4608;
    localparam int BASE1 = 4608;
    localparam int LEN1  = 3456;
`ifdef LDPC_ROM_OREG_EN
    localparam int RL = 2;
`else
    localparam int RL = 1;
`endif

    typedef struct {
        int d;
        bit l;
        int p;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, start, rate, abort, dout_rdy;
    logic [IW-1:0] iter_num;
    logic          busy, dout_vld, dout_last, done;
    logic [DW-1:0] dout;
    logic [IW-1:0] pass_idx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ldpc_rom_seq #(
        .DW(DW), .AW(AW), .BASE0(BASE0), .LEN0(LEN0),
        .BASE1(BASE1), .LEN1(LEN1), .IW(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rate(rate), .iter_num(iter_num),
        .abort(abort), .busy(busy), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .dout_last(dout_last), .pass_idx(pass_idx), .done(done)
    );

    // Table image: entry value as a function of absolute ROM address
    function automatic int rom_ref(input int a);
        return (((a * 37) + 5) ^ (a >> 3)) & 32'h3FFF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One run: start, consume under the given ready pattern, check every transfer.
    task automatic run_stream(input int r, input int it, input int rdy_pct,
                              input int abort_pass, input bit poke);
        ent_t          exp_q[$];
        ent_t          ent;
        int            base, len, total, cyc, xfers, first_vld, last_xfer;
        int            stall_left, budget, abort_cyc;
        bit            fin, aborted, prev_stall;
        logic [DW-1:0] hold_d;
        logic          hold_l;
        logic [IW-1:0] hold_p;

        base = (r == 0) ? BASE0 : BASE1;
        len  = (r == 0) ? LEN0 : LEN1;
        for (int p = 0; p <= it; p++) begin
            for (int e = 0; e < len; e++) begin
                ent.d = rom_ref(base + e);
                ent.l = (e == len - 1);
                ent.p = p;
                exp_q.push_back(ent);
            end
        end
        total = exp_q.size();
        budget = total * 8 + 600;
        cyc = 0; xfers = 0; first_vld = -1; last_xfer = -100; stall_left = 0;
        abort_cyc = -1; fin = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
        hold_d = '0; hold_l = 1'b0; hold_p = '0;

        start = 1'b1; rate = r[0]; iter_num = IW'(it);
        while (!fin && cyc < budget) begin
            if (cyc != 0) begin
                start = 1'b0;
                if (poke && cyc == 300) begin
                    start = 1'b1;
                    rate  = ~rate;
                end else if (poke && done) begin
                    start = 1'b1;
                end
            end
            if (rdy_pct >= 100) begin
                dout_rdy = 1'b1;
            end else if (stall_left > 0) begin
                dout_rdy = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                dout_rdy   = 1'b0;
                stall_left = 19;
            end else begin
                dout_rdy = ($urandom_range(0, 99) < rdy_pct);
            end
            abort = 1'b0;
            if (abort_pass >= 0 && !aborted && dout_vld && xfers == abort_pass * len + 1000) begin
                abort     = 1'b1;
                dout_rdy  = 1'b0;
                aborted   = 1'b1;
                abort_cyc = cyc;
            end

            @(negedge clk);
            if (cyc == 1) check_eq("busy_after_start", busy, 1);
            if (aborted) begin
                if (cyc == abort_cyc) begin
                    check_eq("abort_head_data", dout, exp_q[0].d);
                    check_eq("abort_head_pass", pass_idx, abort_pass);
                end else begin
                    check_eq("abort_vld", dout_vld, 0);
                    check_eq("abort_busy", busy, 0);
                    check_eq("abort_no_done", done, 0);
                    if (cyc >= abort_cyc + 4) fin = 1'b1;
                end
            end else begin
                if (dout_vld && first_vld < 0) begin
                    first_vld = cyc;
                    check_eq("first_vld_latency", cyc, RL + 1);
                end
                if (rdy_pct >= 100 && first_vld >= 0 && exp_q.size() > 0)
                    check_eq("no_gap", dout_vld, 1);
                if (prev_stall) begin
                    check_eq("stall_vld", dout_vld, 1);
                    check_eq("stall_data", dout, hold_d);
                    check_eq("stall_last", dout_last, hold_l);
                    check_eq("stall_pass", pass_idx, hold_p);
                end
                if (dout_vld && dout_rdy) begin
                    if (exp_q.size() == 0) begin
                        check_eq("entry_count", xfers + 1, total);
                    end else begin
                        ent = exp_q.pop_front();
                        check_eq("data", dout, ent.d);
                        check_eq("last", dout_last, ent.l);
                        check_eq("pass_idx", pass_idx, ent.p);
                        xfers++;
                        if (exp_q.size() == 0) last_xfer = cyc;
                    end
                end
                if (done) begin
                    check_eq("done_timing", cyc, last_xfer + 1);
                    check_eq("busy_at_done", busy, 0);
                    check_eq("entries_at_done", xfers, total);
                    if (rdy_pct >= 100) check_eq("start_to_done", cyc, total + RL + 1);
                    fin = 1'b1;
                end
                prev_stall = dout_vld && !dout_rdy;
                hold_d = dout; hold_l = dout_last; hold_p = pass_idx;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
        check_eq("stream_finished", fin, 1);
        if (fin && !aborted) begin
            check_eq("idle_after_done", busy, 0);
            check_eq("done_pulse_width", done, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rate = 1'b0; abort = 1'b0;
        dout_rdy = 1'b0; iter_num = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_vld", dout_vld, 0);
        check_eq("rst_last", dout_last, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass_idx, 0);
        check_eq("rst_dout", dout, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single pass, rate 1/2, full throughput
        run_stream(0, 0, 100, -1, 1'b0);
        // Three passes, rate 3/4, with start poked mid-run and in the done cycle
        run_stream(1, 2, 100, -1, 1'b1);
        // Start in the cycle after done, random back-pressure
        run_stream(1, 0, 50, -1, 1'b0);
        // Abort at entry 1000 of pass 1 while stalled
        run_stream(1, 1, 100, 1, 1'b0);
        // Restart after abort from the table base, random back-pressure
        run_stream(0, 0, 50, -1, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_idle_noop", busy, 0);

        // Asynchronous reset mid-stream
        start = 1'b1; rate = 1'b0; iter_num = '0; dout_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check_eq("pre_rst_vld", dout_vld, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_vld", dout_vld, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_dout", dout, 0);
        check_eq("arst_last", dout_last, 0);
        check_eq("arst_pass", pass_idx, 0);
        check_eq("arst_done", done, 0);
        #3 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle_vld", dout_vld, 0);
            check_eq("post_rst_idle_busy", busy, 0);
        end
        @(posedge clk); #1;
        run_stream(1, 0, 100, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
